// File: rtl/path_replayer_if.sv
// rtl/path_replayer_if.sv - start/storage-read/move-stream signals of path_replayer
interface path_replayer_if;
    logic       start;
    logic [8:0] pathLen;
    logic       rdEn;
    logic [7:0] rdAddr;
    logic [7:0] rdData;
    logic [1:0] dir;
    logic       dirValid;
    logic       dirReady;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] stepCnt;

    modport master (
        output start, pathLen, rdData, dirReady,
        input  rdEn, rdAddr, dir, dirValid, busy, done, err, stepCnt
    );

    modport slave (
        input  start, pathLen, rdData, dirReady,
        output rdEn, rdAddr, dir, dirValid, busy, done, err, stepCnt
    );
endinterface

// File: rtl/path_replayer.sv
// rtl/path_replayer.sv - replays stored grid locations as a stream of move codes
// Optional adjacency checking (ERR state, sticky err) enabled by PATH_REPLAYER_CHECK_EN.
module path_replayer #(
    parameter int MAX_LEN = 256
) (
    input  logic           clk,
    input  logic           rst,
    path_replayer_if.slave pr
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_EMIT, S_FIN, S_ERR
    } state_t;

    localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] idx_q;
    logic [8:0] len_q;
    logic [7:0] cur_q;
    logic [1:0] dir_q;
    logic [7:0] step_q;
    logic [8:0] start_len;
    logic [1:0] dir_calc;
    logic       last_idx;
    logic       cap_bad;
    logic [3:0] row_o, col_o, row_n, col_n;

    assign start_len = (pr.pathLen > MAX_LEN_C) ? MAX_LEN_C : pr.pathLen;
    assign last_idx  = ({1'b0, idx_q} == (len_q - 9'd1));

    // cur_q still holds the previous location while rdData carries the new one
    assign row_o = cur_q[7:4];
    assign col_o = cur_q[3:0];
    assign row_n = pr.rdData[7:4];
    assign col_n = pr.rdData[3:0];

    always_comb begin
        dir_calc = 2'b10;
        if (row_n < row_o)      dir_calc = 2'b00;
        else if (row_n > row_o) dir_calc = 2'b11;
        else if (col_n > col_o) dir_calc = 2'b01;
    end

`ifdef PATH_REPLAYER_CHECK_EN
    logic err_q;
    logic adjacent;

    // widened to 5 bits so 4'hF + 1 never wraps to 0
    assign adjacent = ((row_n == row_o) &&
                       (({1'b0, col_o} + 5'd1 == {1'b0, col_n}) ||
                        ({1'b0, col_n} + 5'd1 == {1'b0, col_o}))) ||
                      ((col_n == col_o) &&
                       (({1'b0, row_o} + 5'd1 == {1'b0, row_n}) ||
                        ({1'b0, row_n} + 5'd1 == {1'b0, row_o})));
    assign cap_bad = !adjacent;
    assign pr.err  = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && pr.start) begin
            err_q <= 1'b0;
        end else if (state_q == S_CAP && idx_q != 8'd0 && cap_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign cap_bad = 1'b0;
    assign pr.err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (pr.start) state_d = (start_len < 9'd2) ? S_FIN : S_RD;
            S_RD:   state_d = S_CAP;
            S_CAP: begin
                if (idx_q == 8'd0) state_d = S_RD;
                else if (cap_bad)  state_d = S_ERR;
                else               state_d = S_EMIT;
            end
            S_EMIT: if (pr.dirReady) state_d = last_idx ? S_FIN : S_RD;
            S_FIN:  state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pr.rdEn     = (state_q == S_RD);
        pr.rdAddr   = (state_q == S_RD) ? idx_q : 8'd0;
        pr.dirValid = (state_q == S_EMIT);
        pr.busy     = (state_q != S_IDLE);
        pr.done     = (state_q == S_FIN) || (state_q == S_ERR);
        pr.dir      = dir_q;
        pr.stepCnt  = step_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= 8'd0;
            len_q  <= 9'd0;
            cur_q  <= 8'd0;
            dir_q  <= 2'b00;
            step_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pr.start) begin
                        step_q <= 8'd0;
                        if (start_len >= 9'd2) begin
                            len_q <= start_len;
                            idx_q <= 8'd0;
                        end
                    end
                end
                S_CAP: begin
                    cur_q <= pr.rdData;
                    if (idx_q == 8'd0) idx_q <= 8'd1;
                    else               dir_q <= dir_calc;
                end
                S_EMIT: begin
                    if (pr.dirReady) begin
                        step_q <= step_q + 8'd1;
                        if (!last_idx) idx_q <= idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_path_replayer.sv
// tb/tb_path_replayer.sv - directed self-checking bench for path_replayer
module tb_path_replayer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    path_replayer_if pr ();

    path_replayer #(.MAX_LEN(256)) dut (
        .clk (clk),
        .rst (rst),
        .pr  (pr)
    );

    logic [7:0] mem [256];
    always @(posedge clk) if (pr.rdEn) pr.rdData <= mem[pr.rdAddr];

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         dv_cnt;
    int         done_cnt;
    int         done_cyc;
    logic [7:0] addr_q [$];
    logic [1:0] dir_q  [$];
    int         xfer_cyc [$];

    always @(negedge clk) begin
        cyc++;
        if (pr.rdEn) addr_q.push_back(pr.rdAddr);
        if (pr.dirValid) dv_cnt++;
        if (pr.dirValid && pr.dirReady) begin
            dir_q.push_back(pr.dir);
            xfer_cyc.push_back(cyc);
        end
        if (pr.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        addr_q.delete();
        dir_q.delete();
        xfer_cyc.delete();
        dv_cnt   = 0;
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic start_path(input logic [8:0] len);
        @(posedge clk); #1;
        pr.pathLen = len;
        pr.start   = 1'b1;
        @(posedge clk); #1;
        pr.start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!pr.done && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, 32'(pr.done), 32'd1);
        @(negedge clk); #1;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(pr.done), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int n = 0;
        while (!pr.dirValid && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_valid"}, 32'(pr.dirValid), 32'd1);
    endtask

    task automatic check_moves(input string tag, input int n, input logic [15:0] exp);
        check({tag, "_nmoves"}, 32'(dir_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check($sformatf("%s_move%0d", tag, i), 32'(dir_q[i]), 32'(exp[2*i +: 2]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},     32'(pr.busy),     32'd0);
        check({tag, "_done"},     32'(pr.done),     32'd0);
        check({tag, "_err"},      32'(pr.err),      32'd0);
        check({tag, "_dirValid"}, 32'(pr.dirValid), 32'd0);
        check({tag, "_rdEn"},     32'(pr.rdEn),     32'd0);
        check({tag, "_rdAddr"},   32'(pr.rdAddr),   32'd0);
        check({tag, "_stepCnt"},  32'(pr.stepCnt),  32'd0);
        check({tag, "_dir"},      32'(pr.dir),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        pr.start    = 1'b0;
        pr.pathLen  = 9'd0;
        pr.dirReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;

        // pathLen=1: straight to FIN, nothing read or emitted
        clear_mon();
        start_path(9'd1);
        check("short_done_now", 32'(pr.done), 32'd1);
        wait_done("short", 5);
        check("short_reads", 32'(addr_q.size()), 32'd0);
        check("short_dv", 32'(dv_cnt), 32'd0);
        check("short_step", 32'(pr.stepCnt), 32'd0);

        mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h11;
        pr.dirReady = 1'b1;
        clear_mon();
        start_path(9'd2);
        wait_done("len2", 30);
        check_moves("len2", 1, 16'b01);
        check("len2_step", 32'(pr.stepCnt), 32'd1);
        check("len2_reads", 32'(addr_q.size()), 32'd2);

        clear_mon();
        start_path(9'd3);
        wait_done("len3", 30);
        check_moves("len3", 2, 16'b11_01);
        check("len3_step", 32'(pr.stepCnt), 32'd2);
        check("len3_done_lat", 32'(done_cyc - xfer_cyc[1]), 32'd1);
        check("len3_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
        check("len3_addr2", 32'(addr_q[2]), 32'd2);
        check("len3_donecnt", 32'(done_cnt), 32'd1);

        // back-pressure: dir must hold while dirReady is low
        mem[0] = 8'h55; mem[1] = 8'h45;
        pr.dirReady = 1'b0;
        clear_mon();
        start_path(9'd2);
        wait_valid("stall", 20);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_dv%0d", i), 32'(pr.dirValid), 32'd1);
            check($sformatf("stall_dir%0d", i), 32'(pr.dir), 32'd0);
            check($sformatf("stall_step%0d", i), 32'(pr.stepCnt), 32'd0);
            @(posedge clk); #1;
        end
        pr.dirReady = 1'b1;
        wait_done("stall", 10);
        check_moves("stall", 1, 16'b00);
        check("stall_step", 32'(pr.stepCnt), 32'd1);

        mem[0] = 8'h00; mem[1] = 8'h22;
        clear_mon();
        start_path(9'd2);
        wait_done("nonadj", 30);
`ifdef PATH_REPLAYER_CHECK_EN
        check("nonadj_err", 32'(pr.err), 32'd1);
        check("nonadj_dv", 32'(dv_cnt), 32'd0);
        check_moves("nonadj", 0, 16'b0);
        mem[1] = 8'h01;
        start_path(9'd2);
        check("nonadj_errclr", 32'(pr.err), 32'd0);
        wait_done("nonadj_ok", 30);
`else
        check_moves("nonadj", 1, 16'b11);
        check("nonadj_err", 32'(pr.err), 32'd0);
`endif

        // start during EMIT must be ignored
        mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h11; mem[3] = 8'h10; mem[4] = 8'h20;
        pr.dirReady = 1'b0;
        clear_mon();
        start_path(9'd4);
        wait_valid("ign", 20);
        pr.pathLen = 9'd2;
        pr.start   = 1'b1;
        @(posedge clk); #1;
        pr.start   = 1'b0;
        check("ign_step", 32'(pr.stepCnt), 32'd0);
        pr.dirReady = 1'b1;
        wait_done("ign", 40);
        check_moves("ign", 3, 16'b10_11_01);
        check("ign_step_end", 32'(pr.stepCnt), 32'd3);
        check("ign_reads", 32'(addr_q.size()), 32'd4);

        // reset during EMIT of move 2 of 4
        pr.dirReady = 1'b0;
        clear_mon();
        start_path(9'd5);
        wait_valid("rst_m1", 20);
        pr.dirReady = 1'b1;
        @(posedge clk); #1;
        pr.dirReady = 1'b0;
        wait_valid("rst_m2", 20);
        check("rst_pre_dir", 32'(pr.dir), 32'd3);
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        pr.dirReady = 1'b1;
        clear_mon();
        start_path(9'd4);
        wait_done("after_rst", 40);
        check_moves("after_rst", 3, 16'b10_11_01);
        check("after_rst_step", 32'(pr.stepCnt), 32'd3);
        check("after_rst_addr0", 32'(addr_q[0]), 32'd0);
        check("after_rst_donecnt", 32'(done_cnt), 32'd1);

        // maximum length and clamping
        for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 1) ? 8'h01 : 8'h00;
        clear_mon();
        start_path(9'd256);
        wait_done("len256", 1000);
        check("len256_step", 32'(pr.stepCnt), 32'd255);
        check("len256_moves", 32'(dir_q.size()), 32'd255);
        check("len256_reads", 32'(addr_q.size()), 32'd256);
        check("len256_lastaddr", 32'(addr_q[255]), 32'd255);
        check("len256_lastdir", 32'(dir_q[254]), 32'd1);
        check("len256_dir1", 32'(dir_q[1]), 32'd2);

        clear_mon();
        start_path(9'd300);
        wait_done("clamp", 1000);
        check("clamp_step", 32'(pr.stepCnt), 32'd255);
        check("clamp_reads", 32'(addr_q.size()), 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/path_replayer.md
PATH_REPLAYER -- requirements
Module: path_replayer

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 256, giving the maximum number of stored path entries; the path length range is 0..MAX_LEN.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to replay the stored path.
REQ-005 The block SHALL have port pathLen, input, 9, the number of valid path entries, sampled on start.
REQ-006 The block SHALL have port rdEn, output, 1, the read strobe to path storage.
REQ-007 The block SHALL have port rdAddr, output, 8, the storage index, where 0 is the first (oldest) pushed location.
REQ-008 The block SHALL have port rdData, input, 8, the stored location, valid one cycle after rdEn; bits [7:4] are the row and bits [3:0] are the column.
REQ-009 The block SHALL have port dir, output, 2, the move code: 00 up (row-1), 01 right (col+1), 10 left (col-1), 11 down (row+1).
REQ-010 The block SHALL have port dirValid, output, 1, indicating that dir holds a move.
REQ-011 The block SHALL have port dirReady, input, 1, the consumer acceptance signal.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when the replay finishes.
REQ-014 The block SHALL have port err, output, 1, a sticky error flag for non-adjacent locations (see Configuration).
REQ-015 The block SHALL have port stepCnt, output, 8, the number of moves accepted since the last start.

Function
REQ-016 The FSM SHALL have the states IDLE, RD, CAP, EMIT, FIN and ERR.
REQ-017 In IDLE, start with pathLen<2 SHALL go to FIN with no reads and no moves; with pathLen>=2 it SHALL latch the length, clear stepCnt and err, set idx=0 and go to RD.
REQ-018 RD SHALL assert rdEn for exactly one cycle with rdAddr=idx and then go to CAP.
REQ-019 In CAP, the previous location SHALL be replaced by the current location and the current location by rdData; idx 0 SHALL return to RD with idx=1, and idx>0 SHALL compute dir and go to EMIT.
REQ-020 The dir encoding SHALL be: row-1 with equal column gives 00; column+1 with equal row gives 01; column-1 with equal row gives 10; row+1 with equal column gives 11; 4-bit fields SHALL be compared without wrap-around.
REQ-021 In EMIT, dirValid=1 and dir SHALL hold stable until the cycle with dirReady=1; that cycle SHALL be the transfer.
REQ-022 On a transfer, stepCnt SHALL increment; if idx==len-1 the FSM SHALL go to FIN, else idx SHALL increment and the FSM SHALL go to RD.
REQ-023 The minimum spacing SHALL be 3 cycles per move (RD, CAP, EMIT) when dirReady is held high.
REQ-024 FIN SHALL assert done for one cycle and then go to IDLE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 dirValid SHALL be 0 outside EMIT.
REQ-027 rdEn SHALL be 0 outside RD.
REQ-028 stepCnt SHALL hold its value after FIN until the next accepted start.
REQ-029 The pathLen value 256 SHALL give 255 moves; pathLen>MAX_LEN SHALL be clamped to MAX_LEN.

Reset
REQ-030 When rst=0, the block SHALL asynchronously force state IDLE and idx=0.
REQ-031 When rst=0, stepCnt, dir, dirValid, rdEn, rdAddr, busy, done and err SHALL all be 0.
REQ-032 Reset asserted mid-replay SHALL abandon the replay with no done pulse; the first start after release SHALL replay from index 0.

Configuration
REQ-033 With macro PATH_REPLAYER_CHECK_EN defined, a CAP step where the two locations are not exactly one orthogonal step apart SHALL go to ERR.
REQ-034 ERR SHALL set err, emit no move and pulse done for one cycle; err SHALL stay set until the next accepted start or reset.
REQ-035 Without PATH_REPLAYER_CHECK_EN, err SHALL be tied to 0 and ERR SHALL be unreachable.
REQ-036 Without PATH_REPLAYER_CHECK_EN, dir for non-adjacent locations SHALL be chosen by priority: row decrease 00, row increase 11, column increase 01, else 10.

Verification
REQ-037 Storage 0x00,0x01,0x11 with pathLen=2 then 3 and dirReady=1 -> moves 01 then 11, stepCnt=2, done one cycle after the second transfer.
REQ-038 pathLen=1 and start -> done one cycle later (FIN), rdEn never asserted, dirValid never asserted, stepCnt=0.
REQ-039 Storage 0x55,0x45 with dirReady held low for 5 cycles in EMIT -> dirValid=1 and dir=00 stable for all 5 cycles, one transfer on dirReady, stepCnt=1.
REQ-040 With PATH_REPLAYER_CHECK_EN, storage 0x00,0x22 -> err=1, done pulse, no dirValid; without the macro -> one move of 11.
REQ-041 A start pulse during EMIT -> no effect on idx, stepCnt or the output sequence.
REQ-042 rst=0 during EMIT of move 2 of 4 -> all outputs 0 immediately; after release, start -> replay from index 0, 3 moves, stepCnt=3.
